mux_ff_scan: RTL and testbench
==============================

# mux_ff_scan

Parametrised registered N:1 channel selector with output handshake: the next generation of the team's mux-into-flop block. It widens the data path to WIDTH bits and NCH channels, and adds an auto-scan mode that cycles through channels with a programmable dwell. It also adds a valid/ready output with back-pressure and an out-of-range select flag. It sits between the multi-source sample inputs and a single downstream consumer.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- NCH, 4, number of input channels (≥2; need not be a power of two)
- SELW, $clog2(NCH), select/pointer width (derived; do not override)
- DWELLW, 4, width of dwell count
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high; priority over every other input
- din  input  NCH*WIDTH  packed channels; channel k = din[k*WIDTH +: WIDTH]
- mode  input  1  0 = direct select, 1 = auto-scan
- sel  input  SELW  channel index, direct mode only
- en  input  1  capture enable
- dwell  input  DWELLW  scan mode: extra cycles between captures
- out_ready  input  1  downstream accepts q this cycle
- q  output  WIDTH  registered selected data
- q_ch  output  SELW  channel index q was taken from
- q_valid  output  1  q holds an unconsumed sample
- sel_err  output  1  one-cycle pulse: direct-mode capture attempted with sel ≥ NCH

## Operation
- Reset (reset=1 at rising edge) sets these registers to 0: q, q_ch, q_valid, sel_err, the scan pointer ptr, the dwell counter dcnt and the registered mode mode_q.
- Definitions:
  - stall = q_valid & ~out_ready
  - adv = en & ~stall
- stall behaviour: q, q_ch and q_valid hold. In scan mode, dcnt and ptr also freeze.
- Consumption: if q_valid & out_ready and no capture occurs this cycle, q_valid clears. q and q_ch keep their last values; they are never zeroed.
- Mode change:
  - mode_q tracks mode each cycle.
  - In any cycle where mode ≠ mode_q, set ptr=0 and dcnt=0.
  - No capture happens in that cycle; consumption still applies.
- Direct mode (mode=mode_q=0), when adv:
  - sel < NCH: q ← din[sel], q_ch ← sel, q_valid ← 1.
  - sel ≥ NCH: q ← 0, q_ch ← sel, q_valid ← 1, sel_err pulses 1 for one cycle.
- Scan mode (mode=mode_q=1), when adv:
  - If dcnt == dwell: q ← din[ptr], q_ch ← ptr, q_valid ← 1, dcnt ← 0, ptr ← (ptr == NCH-1) ? 0 : ptr+1.
  - Otherwise: dcnt ← dcnt+1, no capture. q_valid clears if it was consumed.
  - sel is ignored in scan mode; sel_err stays 0.
- Capture and consume in the same cycle: the new sample replaces the consumed one and q_valid stays 1.
- dwell is sampled live each cycle. If dwell is lowered below the current dcnt, the counter runs up to its all-ones value, wraps to 0 and continues until it equals dwell; no error is flagged.
- Data is passed through without masking: X/Z on a selected channel appears on q unchanged.
- sel_err is 0 in every cycle where it is not explicitly pulsed.

## Timing
- Direct mode: 1-cycle latency, din[sel] at edge n → q at edge n, visible after the edge. Sustains 1 sample/cycle with out_ready held high.
- Scan mode: one capture every dwell+1 adv cycles. dwell=0 gives one channel per cycle: 0,1,…,NCH-1,0.
- After the mode switches to 1, the first scan capture happens at the (dwell+2)th edge: one settle edge plus dwell+1 counting edges.
- Reset is effective at the edge where it is sampled high. Mid-stream reset drops q_valid at that edge and discards the pending sample. The first capture after reset release needs en=1 at the next edge.
- Outputs are pure register outputs; there is no combinational path from inputs to outputs.

## Test plan
- Reset: hold reset for 2 edges with en=1 and valid data on din → q=0, q_ch=0, q_valid=0, sel_err=0 throughout; first capture happens the edge after release.
- Direct sweep (WIDTH=8, NCH=4): din = {8'hDD, 8'hCC, 8'hBB, 8'hAA}, out_ready=1, sel stepped 0..3 one per edge → q = AA, BB, CC, DD with q_ch 0..3, each 1 cycle after sel. Repeat with channel 2 = X and channel 3 = Z → q shows X and Z.
- Back-pressure: capture AA, then hold out_ready=0 for 3 edges while sel changes → q stays AA and q_valid stays 1. Raise out_ready with en=0 → q_valid drops next edge; q still reads AA.
- Scan with dwell=2 (NCH=4): set mode=1, en=1, out_ready=1 → first capture at the 4th edge after the switch, then every 3 edges; q_ch sequence 0,1,2,3,0. Deassert out_ready for 5 edges mid-scan → q_ch does not advance, and no channel is skipped on resume.
- Out-of-range select (NCH=3, SELW=2): sel=3, en=1 → q=0, q_ch=3, q_valid=1, sel_err high for exactly 1 cycle. With sel=3 in scan mode → sel_err stays 0.
- Reset mid-scan: assert reset when ptr=2 with q_valid=1 → next edge ptr=0, dcnt=0, q_valid=0. After release with mode=1, the first capture is channel 0 after the settle edge plus dwell+1 edges.

Source files
------------

// File: rtl/mux_ff_scan.sv
// Registered NCH:1 channel selector with direct/auto-scan modes, dwell counter,
// valid/ready output handshake and out-of-range select flag.
module mux_ff_scan #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NCH    = 4,
    parameter int unsigned SELW   = $clog2(NCH),
    parameter int unsigned DWELLW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic                 en,
    input  logic [DWELLW-1:0]    dwell,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     q,
    output logic [SELW-1:0]      q_ch,
    output logic                 q_valid,
    output logic                 sel_err
);

    logic [WIDTH-1:0]  q_q, q_d;
    logic [SELW-1:0]   q_ch_q, q_ch_d;
    logic              q_valid_q, q_valid_d;
    logic              sel_err_q, sel_err_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [DWELLW-1:0] dcnt_q, dcnt_d;
    logic              mode_q, mode_d;

    logic              stall;
    logic              adv;
    logic              mode_chg;
    logic              sel_oob;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  ptr_data;

    assign stall    = q_valid_q & ~out_ready;
    assign adv      = en & ~stall;
    assign mode_chg = (mode != mode_q);

    // Index by equality so NCH need not be a power of two and no slice runs off the end.
    always_comb begin
        sel_data = '0;
        ptr_data = '0;
        sel_oob  = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) begin
                sel_data = din[k*WIDTH +: WIDTH];
                sel_oob  = 1'b0;
            end
            if (ptr_q == SELW'(k)) begin
                ptr_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        q_d       = q_q;
        q_ch_d    = q_ch_q;
        q_valid_d = q_valid_q;
        sel_err_d = 1'b0;
        ptr_d     = ptr_q;
        dcnt_d    = dcnt_q;
        mode_d    = mode;

        // Consumption first; a capture below overrides it.
        if (q_valid_q && out_ready) begin
            q_valid_d = 1'b0;
        end

        if (mode_chg) begin
            ptr_d  = '0;
            dcnt_d = '0;
        end else if (!mode_q) begin
            if (adv) begin
                q_ch_d    = sel;
                q_valid_d = 1'b1;
                if (sel_oob) begin
                    q_d       = '0;
                    sel_err_d = 1'b1;
                end else begin
                    q_d = sel_data;
                end
            end
        end else begin
            if (adv) begin
                if (dcnt_q == dwell) begin
                    q_d       = ptr_data;
                    q_ch_d    = ptr_q;
                    q_valid_d = 1'b1;
                    dcnt_d    = '0;
                    ptr_d     = (ptr_q == SELW'(NCH - 1)) ? '0 : ptr_q + SELW'(1);
                end else begin
                    // Wraps through all-ones if dwell was lowered below dcnt.
                    dcnt_d = dcnt_q + DWELLW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q       <= '0;
            q_ch_q    <= '0;
            q_valid_q <= 1'b0;
            sel_err_q <= 1'b0;
            ptr_q     <= '0;
            dcnt_q    <= '0;
            mode_q    <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_ch_q    <= q_ch_d;
            q_valid_q <= q_valid_d;
            sel_err_q <= sel_err_d;
            ptr_q     <= ptr_d;
            dcnt_q    <= dcnt_d;
            mode_q    <= mode_d;
        end
    end

    assign q       = q_q;
    assign q_ch    = q_ch_q;
    assign q_valid = q_valid_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_ff_scan.sv
// Directed bench for mux_ff_scan: a 4-channel instance and a 3-channel instance
// sharing clock and control, checked against hand-computed values.
module tb_mux_ff_scan;

    logic        clk;
    logic        reset;
    logic [31:0] din_a;
    logic [23:0] din_b;
    logic        mode;
    logic [1:0]  sel;
    logic        en;
    logic [3:0]  dwell;
    logic        out_ready;

    logic [7:0]  q_a, q_b;
    logic [1:0]  q_ch_a, q_ch_b;
    logic        q_valid_a, q_valid_b;
    logic        sel_err_a, sel_err_b;

    int n_checks;
    int n_pass;

    mux_ff_scan #(.WIDTH(8), .NCH(4), .DWELLW(4)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .din       (din_a),
        .mode      (mode),
        .sel       (sel),
        .en        (en),
        .dwell     (dwell),
        .out_ready (out_ready),
        .q         (q_a),
        .q_ch      (q_ch_a),
        .q_valid   (q_valid_a),
        .sel_err   (sel_err_a)
    );

    mux_ff_scan #(.WIDTH(8), .NCH(3), .DWELLW(4)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .din       (din_b),
        .mode      (mode),
        .sel       (sel),
        .en        (en),
        .dwell     (dwell),
        .out_ready (out_ready),
        .q         (q_b),
        .q_ch      (q_ch_b),
        .q_valid   (q_valid_b),
        .sel_err   (sel_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [7:0] eq, input logic [1:0] ech,
                           input logic ev);
        check({tag, ".q"}, 32'(q_a), 32'(eq));
        check({tag, ".q_ch"}, 32'(q_ch_a), 32'(ech));
        check({tag, ".q_valid"}, 32'(q_valid_a), 32'(ev));
        check({tag, ".sel_err"}, 32'(sel_err_a), 32'd0);
    endtask

    logic [7:0] exp_ch [4];
    logic [7:0] exp_b  [3];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_ch[0] = 8'hAA; exp_ch[1] = 8'hBB; exp_ch[2] = 8'hCC; exp_ch[3] = 8'hDD;
        exp_b[0]  = 8'h11; exp_b[1]  = 8'h22; exp_b[2]  = 8'h33;

        reset     = 1'b1;
        din_a     = 32'hDDCCBBAA;
        din_b     = 24'h332211;
        mode      = 1'b0;
        sel       = 2'd1;
        en        = 1'b1;
        dwell     = 4'd0;
        out_ready = 1'b1;

        // Reset held two edges with en=1 and live data.
        tick();
        check_a("rst0", 8'h00, 2'd0, 1'b0);
        tick();
        check_a("rst1", 8'h00, 2'd0, 1'b0);
        reset = 1'b0;
        sel   = 2'd0;
        tick();
        check_a("post_rst", 8'hAA, 2'd0, 1'b1);

        // Direct sweep, one channel per edge.
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            check_a($sformatf("sweep%0d", i), exp_ch[i], 2'(i), 1'b1);
        end

        // Unknown/high-impedance data passes through unmasked.
        din_a = {8'hzz, 8'hxx, 8'hBB, 8'hAA};
        sel   = 2'd2;
        tick();
        check("xpass.q", 32'(q_a), 32'(din_a[23:16]));
        sel = 2'd3;
        tick();
        check("zpass.q", 32'(q_a), 32'(din_a[31:24]));
        din_a = 32'hDDCCBBAA;

        // Back-pressure holds the sample.
        sel = 2'd0;
        tick();
        check_a("bp_cap", 8'hAA, 2'd0, 1'b1);
        out_ready = 1'b0;
        for (int i = 1; i < 4; i++) begin
            sel = 2'(i);
            tick();
            check_a($sformatf("bp_hold%0d", i), 8'hAA, 2'd0, 1'b1);
        end
        out_ready = 1'b1;
        en        = 1'b0;
        tick();
        check_a("bp_drain", 8'hAA, 2'd0, 1'b0);

        // Scan, dwell=2: settle edge + 3 counting edges before first capture.
        en    = 1'b1;
        dwell = 4'd2;
        mode  = 1'b1;
        sel   = 2'd3;
        tick();
        tick();
        tick();
        check_a("scan_pre", 8'hAA, 2'd0, 1'b0);
        tick();
        check_a("scan_c0", 8'hAA, 2'd0, 1'b1);
        tick();
        check_a("scan_gap", 8'hAA, 2'd0, 1'b0);
        tick();
        tick();
        check_a("scan_c1", 8'hBB, 2'd1, 1'b1);
        tick();
        tick();
        tick();
        check_a("scan_c2", 8'hCC, 2'd2, 1'b1);

        // Stall mid-scan: nothing advances, nothing skipped.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_a($sformatf("scan_stall%0d", i), 8'hCC, 2'd2, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        check_a("scan_resume", 8'hCC, 2'd2, 1'b0);
        tick();
        tick();
        check_a("scan_c3", 8'hDD, 2'd3, 1'b1);
        tick();
        tick();
        tick();
        check_a("scan_c0b", 8'hAA, 2'd0, 1'b1);

        // dwell=0: one channel per edge.
        dwell = 4'd0;
        for (int i = 1; i < 5; i++) begin
            tick();
            check_a($sformatf("scan_d0_%0d", i), exp_ch[i % 4], 2'(i % 4), 1'b1);
        end

        // Reach ptr=2 with a pending sample, then reset mid-scan.
        dwell = 4'd2;
        tick();
        tick();
        tick();
        check_a("pre_rst_c1", 8'hBB, 2'd1, 1'b1);
        reset = 1'b1;
        tick();
        check_a("mid_rst", 8'h00, 2'd0, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        check_a("rst_scan_pre", 8'h00, 2'd0, 1'b0);
        tick();
        check_a("rst_scan_c0", 8'hAA, 2'd0, 1'b1);

        // Out-of-range select on the 3-channel instance.
        reset = 1'b1;
        mode  = 1'b0;
        tick();
        reset = 1'b0;
        sel   = 2'd3;
        tick();
        check("oob.q", 32'(q_b), 32'h00);
        check("oob.q_ch", 32'(q_ch_b), 32'd3);
        check("oob.q_valid", 32'(q_valid_b), 32'd1);
        check("oob.sel_err", 32'(sel_err_b), 32'd1);
        sel = 2'd1;
        tick();
        check("oob_after.sel_err", 32'(sel_err_b), 32'd0);
        check("oob_after.q", 32'(q_b), 32'h22);
        check("oob_after.q_ch", 32'(q_ch_b), 32'd1);

        // Scan with sel=3: no error, channels wrap at 2.
        sel   = 2'd3;
        mode  = 1'b1;
        dwell = 4'd0;
        tick();
        check("b_settle.sel_err", 32'(sel_err_b), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("b_scan%0d.q_ch", i), 32'(q_ch_b), 32'(i % 3));
            check($sformatf("b_scan%0d.q", i), 32'(q_b), 32'(exp_b[i % 3]));
            check($sformatf("b_scan%0d.sel_err", i), 32'(sel_err_b), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
